// File: rtl/store_write_arbiter.sv
// -----------------------------------------------------------------------------
// store_write_arbiter
//
// Round-robin arbiter that shares one memory write port among NUM_REQ pipeline
// store requesters. Each grant takes one result/address pair. The write is
// then held on WriteBus/WriteAddress/WriteEnable until the memory returns
// WriteAck. When a request is waiting on the ack cycle, the next write follows
// back-to-back and WriteEnable stays high.
//
// Ports:
//   clock        - system clock, all logic on the rising edge
//   reset        - synchronous, active-high reset
//   req_valid    - per-requester store pending
//   req_data     - packed requester results, slice i at [i*DATA_W +: DATA_W]
//   req_addr     - packed store addresses, slice i at [i*ADDR_W +: ADDR_W]
//   req_ready    - one-hot accept (combinational)
//   WriteBus     - write data: the accepted result, zero-extended
//   WriteAddress - write address
//   WriteEnable  - write request to memory, held until WriteAck
//   WriteAck     - memory accepted the current write
//   grant_id     - index of the requester that owns the current write
//   write_count  - completed writes, wraps at 16 bits
//   done         - idle and no request pending (combinational)
// -----------------------------------------------------------------------------
module store_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int BUS_W   = 128,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [BUS_W-1:0]           WriteBus,
    output logic [ADDR_W-1:0]          WriteAddress,
    output logic                       WriteEnable,
    input  logic                       WriteAck,
    output logic [ID_W-1:0]            grant_id,
    output logic [15:0]                write_count,
    output logic                       done
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [BUS_W-1:0]    bus_reg, bus_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic                we_reg, we_next;
    logic [ID_W-1:0]     grant_reg, grant_next;
    logic [15:0]         count_reg, count_next;
    logic [ID_W-1:0]     ptr_reg, ptr_next;

    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

    logic                accept_ok;
    logic                accept;
    logic                ack_done;
    logic                winner_found;
    logic [ID_W-1:0]     winner_idx;
    // One extra bit so that ptr + k (at most 2*NUM_REQ-1) cannot overflow
    // before the modulo wrap.
    logic [ID_W:0]       cand;

    // Unpack the flat requester buses and build the one-hot ready vector.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign data_arr[gi]  = req_data[gi*DATA_W +: DATA_W];
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign req_ready[gi] = accept && (winner_idx == ID_W'(gi));
        end
    endgenerate

    assign ack_done  = (state_reg == BUSY) && WriteAck;
    assign accept_ok = (state_reg == IDLE) || ack_done;
    assign accept    = accept_ok && winner_found;

    // Search from ptr+1 upward, modulo NUM_REQ. The first valid requester
    // wins. Because the pointer moves to the last winner, each requester
    // is visited once per NUM_REQ grants.
    always_comb begin
        winner_found = 1'b0;
        winner_idx   = '0;
        cand         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr_reg} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!winner_found && req_valid[cand[ID_W-1:0]]) begin
                winner_found = 1'b1;
                winner_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Next-state logic for the write port.
    always_comb begin
        state_next = state_reg;
        bus_next   = bus_reg;
        addr_next  = addr_reg;
        we_next    = we_reg;
        grant_next = grant_reg;
        count_next = count_reg;
        ptr_next   = ptr_reg;

        if (ack_done) begin
            count_next = count_reg + 16'd1;
        end

        if (accept) begin
            // A new write starts, from IDLE or back-to-back on the ack cycle.
            state_next = BUSY;
            bus_next   = BUS_W'(data_arr[winner_idx]);
            addr_next  = addr_arr[winner_idx];
            we_next    = 1'b1;
            grant_next = winner_idx;
            ptr_next   = winner_idx;
        end else if (ack_done) begin
            // The last write is complete and nothing is waiting. Clear the
            // buses. grant_id keeps the last owner.
            state_next = IDLE;
            bus_next   = '0;
            addr_next  = '0;
            we_next    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            bus_reg   <= '0;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            grant_reg <= '0;
            count_reg <= '0;
            ptr_reg   <= ID_W'(NUM_REQ - 1);
        end else begin
            state_reg <= state_next;
            bus_reg   <= bus_next;
            addr_reg  <= addr_next;
            we_reg    <= we_next;
            grant_reg <= grant_next;
            count_reg <= count_next;
            ptr_reg   <= ptr_next;
        end
    end

    assign WriteBus     = bus_reg;
    assign WriteAddress = addr_reg;
    assign WriteEnable  = we_reg;
    assign grant_id     = grant_reg;
    assign write_count  = count_reg;
    assign done         = (state_reg == IDLE) && !(|req_valid);

endmodule

// File: tb/tb_store_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_store_write_arbiter
//
// A transaction-level reference model checks every output of
// store_write_arbiter on every cycle. Directed sequences with literal
// expected values pin the model. A randomized phase follows, and a final
// run wraps write_count through 0xFFFF.
// -----------------------------------------------------------------------------
module tb_store_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int BW = 128;
    localparam int IW = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N-1:0]      req_ready;
    logic [BW-1:0]     WriteBus;
    logic [AW-1:0]     WriteAddress;
    logic              WriteEnable;
    logic              WriteAck = 1'b0;
    logic [IW-1:0]     grant_id;
    logic [15:0]       write_count;
    logic              done;

    int total = 0;
    int bad   = 0;
    bit verbose = 1'b1;

    store_write_arbiter #(
        .NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .BUS_W(BW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .WriteBus(WriteBus),
        .WriteAddress(WriteAddress),
        .WriteEnable(WriteEnable),
        .WriteAck(WriteAck),
        .grant_id(grant_id),
        .write_count(write_count),
        .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. It tracks the write in flight (if any), the last
    // winner, and the number of completed writes. The DUT is checked
    // against it at every falling edge. Inputs are stable then.
    // ------------------------------------------------------------------
    bit              m_en = 1'b0;
    bit              m_busy;
    int              m_last;
    logic [BW-1:0]   m_bus;
    logic [AW-1:0]   m_addr;
    int              m_grant;
    int              m_count;

    always @(negedge clock) begin
        int w;
        bit acc;
        logic [N-1:0] exp_ready;
        w = -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (w < 0 && req_valid[c]) w = c;
        end
        acc = (!m_busy || WriteAck) && (w >= 0);
        exp_ready = '0;
        if (acc) exp_ready[w] = 1'b1;

        if (m_en) begin
            chk("req_ready",    BW'(req_ready),    BW'(exp_ready));
            chk("done",         BW'(done),         BW'(!m_busy && req_valid == '0));
            chk("WriteEnable",  BW'(WriteEnable),  BW'(m_busy));
            chk("WriteBus",     WriteBus,          m_bus);
            chk("WriteAddress", BW'(WriteAddress), BW'(m_addr));
            chk("grant_id",     BW'(grant_id),     BW'(m_grant));
            chk("write_count",  BW'(write_count),  BW'(m_count[15:0]));
        end

        if (reset) begin
            m_en = 1'b1; m_busy = 1'b0; m_last = N - 1;
            m_bus = '0; m_addr = '0; m_grant = 0; m_count = 0;
        end else if (m_en) begin
            bit completed;
            completed = m_busy && WriteAck;
            if (completed) m_count = (m_count + 1) % 65536;
            if (acc) begin
                m_busy = 1'b1;
                m_bus = BW'(req_data[w*DW +: DW]);
                m_addr = req_addr[w*AW +: AW];
                m_grant = w;
                m_last = w;
                if (verbose)
                    $display("xfer req=%0d data=%h addr=%h t=%0t",
                             w, req_data[w*DW +: DW], req_addr[w*AW +: AW], $time);
            end else if (completed) begin
                m_busy = 1'b0; m_bus = '0; m_addr = '0;
            end
        end
    end

    // Wait for the next rising edge. Inputs change 1 ns after it.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; WriteAck = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] d, input logic [AW-1:0] a);
        req_data[i*DW +: DW] = d;
        req_addr[i*AW +: AW] = a;
    endtask

    logic [IW-1:0] rr_exp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Randomized-phase requester state
    bit           pend [N];
    logic [N-1:0] acc_prev;

    initial begin
        // Reset followed by an idle period.
        do_reset();
        repeat (5) cyc();
        #2;
        chk("idle_we",    BW'(WriteEnable),  BW'(0));
        chk("idle_bus",   WriteBus,          BW'(0));
        chk("idle_addr",  BW'(WriteAddress), BW'(0));
        chk("idle_done",  BW'(done),         BW'(1));
        chk("idle_count", BW'(write_count),  BW'(0));
        chk("idle_ready", BW'(req_ready),    BW'(0));

        // A single write, acked on its first write cycle.
        cyc();
        set_req(0, 16'hBEEF, 16'h0040);
        req_valid = 4'b0001;
        #2 chk("single_ready", BW'(req_ready), BW'(4'b0001));
        cyc();
        req_valid = '0; WriteAck = 1'b1;
        #2;
        chk("single_we",    BW'(WriteEnable),  BW'(1));
        chk("single_bus",   WriteBus,          BW'(16'hBEEF));
        chk("single_addr",  BW'(WriteAddress), BW'(16'h0040));
        chk("single_grant", BW'(grant_id),     BW'(0));
        cyc();
        WriteAck = 1'b0;
        #2;
        chk("single_we_off", BW'(WriteEnable), BW'(0));
        chk("single_bus0",   WriteBus,         BW'(0));
        chk("single_count",  BW'(write_count), BW'(1));
        chk("single_done",   BW'(done),        BW'(1));

        // Round-robin with every requester valid and an ack every cycle.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, DW'(16'h1000 + i), AW'(16'h0100 + i));
        req_valid = 4'b1111; WriteAck = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 4) req_valid = '0;
            #2;
            chk("rr_grant", BW'(grant_id),    BW'(rr_exp[i]));
            chk("rr_we",    BW'(WriteEnable), BW'(1));
        end
        cyc();
        #2;
        chk("rr_count", BW'(write_count), BW'(5));
        chk("rr_we_off", BW'(WriteEnable), BW'(0));

        // Stall while req1 waits, then a back-to-back grant on the ack.
        cyc();
        do_reset();
        WriteAck = 1'b0;
        set_req(0, 16'h1111, 16'h0010);
        set_req(1, 16'h2222, 16'h0020);
        req_valid = 4'b0001;
        cyc();
        req_valid = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("stall_ready", BW'(req_ready), BW'(0));
            chk("stall_bus",   WriteBus,       BW'(16'h1111));
            chk("stall_addr",  BW'(WriteAddress), BW'(16'h0010));
            chk("stall_grant", BW'(grant_id),  BW'(0));
            cyc();
        end
        WriteAck = 1'b1;
        #2 chk("stall_ack_ready", BW'(req_ready), BW'(4'b0010));
        cyc();
        req_valid = '0;
        #2;
        chk("b2b_grant", BW'(grant_id), BW'(1));
        chk("b2b_bus",   WriteBus,      BW'(16'h2222));
        chk("b2b_we",    BW'(WriteEnable), BW'(1));
        cyc();
        WriteAck = 1'b0;

        // Reset while a write is stalled.
        do_reset();
        set_req(0, 16'hAAAA, 16'h0001);
        req_valid = 4'b0001; WriteAck = 1'b1;
        cyc();
        set_req(0, 16'hBBBB, 16'h0002);
        cyc();
        req_valid = '0; WriteAck = 1'b0;
        cyc();
        #2;
        chk("pre_rst_we",    BW'(WriteEnable), BW'(1));
        chk("pre_rst_count", BW'(write_count), BW'(1));
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #2;
        chk("rst_we",    BW'(WriteEnable), BW'(0));
        chk("rst_count", BW'(write_count), BW'(0));
        chk("rst_bus",   WriteBus,         BW'(0));
        chk("rst_done",  BW'(done),        BW'(1));
        cyc();
        req_valid = 4'b1111;
        #2 chk("rst_ptr_ready", BW'(req_ready), BW'(4'b0001));
        cyc();
        req_valid = '0; WriteAck = 1'b1;
        cyc();
        WriteAck = 1'b0;

        // Randomized traffic. Each requester holds its request until it is
        // accepted, with an occasional drop.
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        acc_prev = '0;
        for (int n = 0; n < 600; n++) begin
            cyc();
            for (int i = 0; i < N; i++) begin
                if (acc_prev[i]) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    set_req(i, DW'($urandom), AW'($urandom));
                end else if (pend[i] && $urandom_range(0, 31) == 0) begin
                    pend[i] = 1'b0;
                end
                req_valid[i] = pend[i];
            end
            WriteAck = ($urandom_range(0, 2) != 0);
            if (n == 300) reset = 1'b1;
            else reset = 1'b0;
            #2;
            acc_prev = req_ready & req_valid;
        end
        req_valid = '0; reset = 1'b0; WriteAck = 1'b1;
        cyc(); cyc();

        // Wrap write_count through 0xFFFF.
        verbose = 1'b0;
        do_reset();
        set_req(0, 16'h5A5A, 16'h0ABC);
        req_valid = 4'b0001; WriteAck = 1'b1;
        for (int n = 0; n < 70000 && write_count != 16'hFFFF; n++) cyc();
        #2 chk("wrap_ffff", BW'(write_count), BW'(16'hFFFF));
        cyc();
        #2 chk("wrap_zero", BW'(write_count), BW'(0));
        req_valid = '0;
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_write_arbiter.md
Name: store_write_arbiter

Overview:
- Round-robin arbiter sharing the single store write port (WriteBus/WriteAddress/WriteEnable) between NUM_REQ pipeline store requesters.
- Accepts one result/address pair per grant and drives the memory write until memory acknowledges.
- Issues back-to-back writes when requests are pending.
- Sits between the parallel pipeline lanes and the result memory; replaces direct per-lane write ports.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 16, width of each requester result
ADDR_W, 16, width of store address
BUS_W, 128, memory write bus width (BUS_W >= DATA_W)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  requester i has a store pending
req_data  input  NUM_REQ*DATA_W  result of requester i in slice [i*DATA_W +: DATA_W]
req_addr  input  NUM_REQ*ADDR_W  store address of requester i in slice [i*ADDR_W +: ADDR_W]
req_ready  output  NUM_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i]
WriteBus  output  BUS_W  write data, accepted result zero-extended
WriteAddress  output  ADDR_W  write address
WriteEnable  output  1  write request to memory, held until WriteAck
WriteAck  input  1  memory accepted current write (sampled only while WriteEnable=1)
grant_id  output  clog2(NUM_REQ)  index of requester owning the current write
write_count  output  16  completed writes, wraps 0xFFFF->0
done  output  1  high when idle and no request pending

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. Reset values: state=IDLE, WriteBus=0, WriteAddress=0, WriteEnable=0, grant_id=0, write_count=0, round-robin pointer=NUM_REQ-1 (requester 0 wins first).
- Reset mid-write: the in-flight write is dropped, with no ack wait and no count increment.
- States:
  - IDLE: no write outstanding.
  - BUSY: WriteEnable=1, waiting for WriteAck.
- Accept window: accept_ok = (state==IDLE) | (state==BUSY & WriteAck).
- Winner selection:
  - The winner is the first i with req_valid[i]=1, searching from ptr+1 upward modulo NUM_REQ.
  - req_ready is combinational: req_ready[winner]=1 only when accept_ok and any req_valid; all other bits are 0.
  - req_ready never has more than one bit set.
- On accept (cycle N), at the edge ending N:
  - WriteBus <= {zeros, req_data slice}; WriteAddress <= req_addr slice.
  - WriteEnable <= 1; grant_id <= winner; ptr <= winner; state <= BUSY.
  - The write is visible in cycle N+1 (latency 1).
- BUSY with WriteAck=0: all outputs held stable, no accept.
- BUSY with WriteAck=1:
  - write_count increments.
  - If a winner exists in the same cycle, it is accepted, giving back-to-back writes with WriteEnable staying 1.
  - Otherwise state <= IDLE, WriteEnable <= 0, WriteBus <= 0, WriteAddress <= 0; grant_id holds.
- WriteAck while IDLE is ignored.
- Requester rules: must hold valid/data/addr stable until accepted. Dropping valid before accept is tolerated; that request is simply not taken.
- done = (state==IDLE) & ~|req_valid. Combinational; reset value 1 when no requests are asserted.
- Fairness: a requester that is continuously valid is granted within NUM_REQ accepts.
- write_count wraps silently at 16 bits.

Test Plan:
- Reset, then req_valid=0 for 5 cycles -> WriteEnable=0, WriteBus=0, WriteAddress=0, done=1, write_count=0, req_ready=0.
- req_valid=0001, data0=0xBEEF, addr0=0x0040, WriteAck=1 on the first write cycle -> req_ready=0001 in cycle N; WriteEnable=1, WriteBus=0x...0000BEEF, WriteAddress=0x0040, grant_id=0 in N+1; WriteEnable=0, buses 0 in N+2; write_count=1; done=1.
- All four valid continuously, WriteAck=1 every cycle -> grants in order 0,1,2,3,0 with WriteEnable held high; write_count=5 after 5 acks.
- req0 valid, WriteAck held 0 for 4 cycles, req1 raised meanwhile -> WriteBus/WriteAddress/grant_id stable, req_ready=0000 throughout. On the ack cycle, req_ready=0010; next cycle grant_id=1.
- Reset asserted while BUSY with WriteAck=0 -> next cycle WriteEnable=0, state IDLE, write_count unchanged from pre-reset value cleared to 0, ptr restarted (req0 wins next).
- Preload write_count=0xFFFF via 65535 acks, then one more write -> write_count=0x0000.
